// File: rtl/pd0_elastic_alu_pipe.sv
// W-bit ALU feeding an elastic STAGES-deep valid/ready pipeline with bubble collapsing.
// Optional flush port enabled by defining PIPE_FLUSH_EN.
module pd0_elastic_alu_pipe #(
  parameter int W      = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [W-1:0]     in_op1,
  input  logic [W-1:0]     in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [W-1:0]      res_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [W-1:0]      alu_res;
  logic              accept;
  logic              flush_i;

`ifdef PIPE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(in_sel))
      OP_ADD: alu_res = in_op1 + in_op2;
      OP_SUB: alu_res = in_op1 - in_op2;
      OP_AND: alu_res = in_op1 & in_op2;
      OP_OR:  alu_res = in_op1 | in_op2;
      default: alu_res = '0;
    endcase
  end

  // Advance chain ripples from the sink back to the input so a full pipe still
  // accepts a beat in the same cycle it emits one.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready || !v[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v[k+1] || adv[k+1];
    end
  end

  assign in_ready  = (!v[0] || adv[0]) && !flush_i;
  assign accept    = in_valid && in_ready;
  assign out_valid = v[STAGES-1];
  assign out_res   = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

  // NOTE: data registers are reset as well as valids so out_res/out_tag read 0
  // after reset; a valid-only reset would leave them undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else if (flush_i) begin
      v <= '0;
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        if (adv[k]) begin
          v[k]     <= v[k-1];
          res_q[k] <= res_q[k-1];
          tag_q[k] <= tag_q[k-1];
        end
      end
      if (adv[0]) begin
        v[0] <= accept;
        if (accept) begin
          res_q[0] <= alu_res;
          tag_q[0] <= in_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_pd0_elastic_alu_pipe.sv
// Directed self-checking bench for pd0_elastic_alu_pipe (W=32, STAGES=3, TAG_W=4).
// Exercises the flush port too when PIPE_FLUSH_EN is defined.
module tb_pd0_elastic_alu_pipe;

  localparam int W      = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [W-1:0]     in_op1;
  logic [W-1:0]     in_op2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;
`ifdef PIPE_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0]       b_sel [16];
  logic [W-1:0]     b_op1 [16];
  logic [W-1:0]     b_op2 [16];
  logic [TAG_W-1:0] b_tag [16];
  logic [W-1:0]     e_res [16];

  pd0_elastic_alu_pipe #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .occupancy(occupancy)
`ifdef PIPE_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams beats 0..nb-1 from the b_* tables; out_ready is low for n in [st_lo, st_hi).
  // full_mode checks steady-state occupancy/throughput for n in [3, nb-1].
  task automatic run(input int nb, input int st_lo, input int st_hi, input bit full_mode);
    int nxt = 0;
    int got = 0;
    int last_emit = -1;
    bit prev_stall = 0;
    logic [W-1:0] prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    for (int n = 0; n < 80 && got < nb; n++) begin
      in_valid  = (nxt < nb);
      in_sel    = b_sel[nxt[3:0]];
      in_op1    = b_op1[nxt[3:0]];
      in_op2    = b_op2[nxt[3:0]];
      in_tag    = b_tag[nxt[3:0]];
      out_ready = !(n >= st_lo && n < st_hi);
      #1;
      if (prev_stall) begin
        check("stall_hold_res", out_res, prev_res);
        check("stall_hold_tag", out_tag, prev_tag);
      end
      if (st_hi > st_lo && n == st_lo + 3) begin
        check("stall_full_occ", occupancy, 3);
        check("stall_in_ready", in_ready, 0);
      end
      if (full_mode && n >= 3 && n < nb) begin
        check("full_occ", occupancy, 3);
        check("full_accept_emit", {in_valid && in_ready, out_valid && out_ready}, 2'b11);
      end
      if (occupancy > 2'(STAGES)) check("occ_bound", occupancy, STAGES);
      if (in_valid && in_ready) nxt++;
      if (out_valid && out_ready) begin
        if (got < nb) begin
          check($sformatf("res[%0d]", got), out_res, e_res[got[3:0]]);
          check($sformatf("tag[%0d]", got), out_tag, b_tag[got[3:0]]);
        end
        got++;
        last_emit = n;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_res;
      prev_tag   = out_tag;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("beats_delivered", got, nb);
    if (full_mode) check("last_emit_cycle", last_emit, nb + STAGES - 1);
    repeat (4) begin
      #1;
      check("no_extra_beat", out_valid, 0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_op1 = '0; in_op2 = '0;
    in_tag = '0; out_ready = 1'b1;
`ifdef PIPE_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_in_ready", in_ready, 1);

    // Latency: ADD 5+3 accepted at cycle c, visible at c+3.
    in_valid = 1'b1; in_sel = 2'b00; in_op1 = 5; in_op2 = 3; in_tag = 4'h1;
    #1;
    check("lat_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("lat_occ_c1", occupancy, 1);
    check("lat_valid_c1", out_valid, 0);
    tick();
    check("lat_valid_c2", out_valid, 0);
    tick();
    check("lat_valid_c3", out_valid, 1);
    check("lat_res", out_res, 8);
    check("lat_tag", out_tag, 4'h1);
    tick();
    check("lat_drained", out_valid, 0);
    check("lat_occ_empty", occupancy, 0);

    // ALU ops with tags 2..5.
    b_sel[0] = 2'b01; b_op1[0] = 10;        b_op2[0] = 4;        b_tag[0] = 4'h2; e_res[0] = 32'h0000_0006;
    b_sel[1] = 2'b01; b_op1[1] = 0;         b_op2[1] = 1;        b_tag[1] = 4'h3; e_res[1] = 32'hFFFF_FFFF;
    b_sel[2] = 2'b10; b_op1[2] = 32'hF0F0;  b_op2[2] = 32'h0FF0; b_tag[2] = 4'h4; e_res[2] = 32'h0000_00F0;
    b_sel[3] = 2'b11; b_op1[3] = 32'hF000;  b_op2[3] = 32'h000F; b_tag[3] = 4'h5; e_res[3] = 32'h0000_F00F;
    run(4, 0, 0, 1'b0);

    // Beats 1..8 (ADD i + 100) with out_ready low for 5 cycles from cycle 2.
    for (int i = 0; i < 8; i++) begin
      b_sel[i] = 2'b00; b_op1[i] = 32'(i + 1); b_op2[i] = 100;
      b_tag[i] = 4'(i + 1); e_res[i] = 32'(i + 101);
    end
    run(8, 2, 7, 1'b0);

    // 13 beats at full rate: 10 cycles at occupancy 3 with accept and emit together.
    for (int i = 0; i < 13; i++) begin
      b_sel[i] = 2'b01; b_op1[i] = 32'(1000 + i); b_op2[i] = 32'(2 * i);
      b_tag[i] = 4'(i); e_res[i] = 32'(1000 - i);
    end
    run(13, 0, 0, 1'b1);

    // Reset mid-stream.
    in_valid = 1'b1; in_sel = 2'b10; in_op1 = 32'hFF; in_op2 = 32'h3C; in_tag = 4'h9;
    out_ready = 1'b0;
    repeat (3) tick();
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_res", out_res, 32'h3C);
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_res", out_res, 0);
    check("mid_rst_in_ready", in_ready, 1);

`ifdef PIPE_FLUSH_EN
    in_valid = 1'b1; in_sel = 2'b00; in_op1 = 7; in_op2 = 7; in_tag = 4'hA;
    out_ready = 1'b0;
    repeat (3) tick();
    check("fl_fill_occ", occupancy, 3);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("fl_occ", occupancy, 0);
    check("fl_out_valid", out_valid, 0);
    repeat (4) begin
      tick();
      check("fl_no_beat", out_valid, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
